// File: rtl/smc_seq_if.sv
// Streaming tuple/result bus for the sequential MOSFET calculator.
// The master drives tuples in; the slave returns the strobed result.
interface smc_seq_if #(
    parameter int DW = 10
);
    logic          in_valid;
    logic [1:0]    mode;
    logic [2:0]    W;
    logic [2:0]    V_GS;
    logic [2:0]    V_DS;
    logic          out_valid;
    logic [DW-1:0] out_n;

    modport master (
        output in_valid, mode, W, V_GS, V_DS,
        input  out_valid, out_n
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS,
        output out_valid, out_n
    );
endinterface

// File: rtl/smc_seq.sv
// Sequential MOSFET calculator: takes N_TR tuples serially, keeps ID and gm
// in descending insertion-sorted lists, and strobes one weighted-sum result.
module smc_seq #(
    parameter int N_TR = 6,
    parameter int DW   = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    smc_seq_if.slave  bus
);
    localparam int          CW   = $clog2(N_TR);
    localparam logic [CW-1:0] LAST = CW'(N_TR - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q;
    logic [DW-1:0] res_q, res_d;
    logic [DW-1:0] id_q  [N_TR];
    logic [DW-1:0] gm_q  [N_TR];
    logic [DW-1:0] id_ins[N_TR];
    logic [DW-1:0] gm_ins[N_TR];

    logic [DW-1:0] w_x, vgs_x, vds_x, vov;
    logic [DW-1:0] id_new, gm_new;
    logic          triode;
    logic          take_beat, clear_lists;

    // Per-beat device equations
    always_comb begin
        w_x    = DW'(bus.W);
        vgs_x  = DW'(bus.V_GS);
        vds_x  = DW'(bus.V_DS);
        vov    = (vgs_x == '0) ? '0 : vgs_x - DW'(1);
        triode = (vov > vds_x);
        if (triode) begin
            id_new = (w_x * vds_x * ((vov << 1) - vds_x)) / DW'(3);
            gm_new = ((w_x << 1) * vds_x) / DW'(3);
        end else begin
            id_new = (w_x * vov * vov) / DW'(3);
            gm_new = ((w_x << 1) * vov) / DW'(3);
        end
    end

    // Lists are descending, so the ">= new" flags form a prefix of ones;
    // the new value lands just after that prefix, below any equal entries.
    always_comb begin
        id_ins[0] = (id_q[0] >= id_new) ? id_q[0] : id_new;
        gm_ins[0] = (gm_q[0] >= gm_new) ? gm_q[0] : gm_new;
        for (int unsigned i = 1; i < N_TR; i++) begin
            id_ins[i] = (id_q[i] >= id_new) ? id_q[i]
                      : ((id_q[i-1] >= id_new) ? id_new : id_q[i-1]);
            gm_ins[i] = (gm_q[i] >= gm_new) ? gm_q[i]
                      : ((gm_q[i-1] >= gm_new) ? gm_new : gm_q[i-1]);
        end
    end

    always_comb begin
        logic [CW-1:0] b;
        b = mode_q[1] ? '0 : CW'(N_TR / 2);
        if (mode_q[0])
            res_d = DW'(3) * id_q[b] + DW'(4) * id_q[b + CW'(1)]
                  + DW'(5) * id_q[b + CW'(2)];
        else
            res_d = gm_q[b] + gm_q[b + CW'(1)] + gm_q[b + CW'(2)];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        take_beat   = 1'b0;
        clear_lists = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.in_valid) begin
                    take_beat = 1'b1;
                    cnt_d     = CW'(1);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (!bus.in_valid) begin
                    clear_lists = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    take_beat = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CALC: state_d = OUT;
            OUT: begin
                clear_lists = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= '0;
            res_q  <= '0;
            for (int unsigned i = 0; i < N_TR; i++) begin
                id_q[i] <= '0;
                gm_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && bus.in_valid)
                mode_q <= bus.mode;
            if (state_q == CALC)
                res_q <= res_d;
            for (int unsigned i = 0; i < N_TR; i++) begin
                if (clear_lists) begin
                    id_q[i] <= '0;
                    gm_q[i] <= '0;
                end else if (take_beat) begin
                    id_q[i] <= id_ins[i];
                    gm_q[i] <= gm_ins[i];
                end
            end
        end
    end

    // Outputs
    always_comb begin
        bus.out_valid = (state_q == OUT);
        bus.out_n     = (state_q == OUT) ? res_q : '0;
    end
endmodule
